// File: rtl/uart_out_unit.sv
// OUT-instruction sink: buffers the low byte of each accepted request in a
// circular FIFO and serialises buffered bytes onto txd as 8N1 frames.
module uart_out_unit #(
  parameter int CLK_PER_BIT = 868,
  parameter int LOG_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 out_req,
  input  logic [31:0]          out_data,
  output logic                 out_busy,
  output logic                 txd,
  output logic [LOG_DEPTH:0]   fifo_count,
  output logic                 tx_active
);

  localparam int DEPTH  = 1 << LOG_DEPTH;
  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [LOG_DEPTH:0] COUNT_FULL = (LOG_DEPTH+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]           r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH:0]   r_count;
  state_t               r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [2:0]           r_bit;
  logic [7:0]           r_shift;
  logic                 r_txd;

  state_t               w_state_next;
  logic [BAUD_W-1:0]    w_baud_next;
  logic [2:0]           w_bit_next;
  logic [7:0]           w_shift_next;
  logic                 w_txd_next;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_baud_last;
  logic                 w_unused_hi;

  assign w_unused_hi = ^out_data[31:8];
  assign out_busy    = (r_count == COUNT_FULL);
  assign w_push      = out_req && !out_busy;
  assign w_baud_last = (r_baud == BAUD_LAST);
  assign fifo_count  = r_count;
  assign tx_active   = (r_state != S_IDLE);
  assign txd         = r_txd;

  // NOTE: storage array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= out_data[7:0];
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (LOG_DEPTH+1)'(1);
        2'b01:   r_count <= r_count - (LOG_DEPTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_txd   <= w_txd_next;
    end
  end

  // txd is computed one cycle ahead so the line itself comes straight from a flop.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_txd_next   = r_txd;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txd_next = 1'b1;
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_baud_next  = '0;
          w_state_next = S_START;
          w_txd_next   = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
          w_txd_next   = r_shift[0];
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_shift_next = r_shift >> 1;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
            w_txd_next   = 1'b1;
          end else begin
            w_bit_next = r_bit + 3'd1;
            w_txd_next = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      S_STOP: begin
        w_txd_next = 1'b1;
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_state_next = S_IDLE;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_txd_next   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_out_unit.sv
// Bench for uart_out_unit: queue-based occupancy/line model checked every cycle,
// plus a UART decoder that pops a byte scoreboard for every frame it sees.
module tb_uart_out_unit;

  localparam int CPB       = 4;
  localparam int LOG_DEPTH = 2;
  localparam int DEPTH     = 1 << LOG_DEPTH;
  localparam int FRAME     = 10 * CPB;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 out_req;
  logic [31:0]          out_data;
  logic                 out_busy;
  logic                 txd;
  logic [LOG_DEPTH:0]   fifo_count;
  logic                 tx_active;

  uart_out_unit #(.CLK_PER_BIT(CPB), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .rstn(rstn), .out_req(out_req), .out_data(out_data),
    .out_busy(out_busy), .txd(txd), .fifo_count(fifo_count), .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual 0x%0h required 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: bytes waiting, byte on the line, and cycles left in its frame.
  logic [7:0] m_fifo[$];
  logic [7:0] sb_q[$];
  logic [7:0] m_cur;
  int         m_left;

  always @(posedge clk or negedge rstn) begin : model_p
    bit push, pop;
    if (!rstn) begin
      m_fifo.delete();
      sb_q.delete();
      m_cur  = '0;
      m_left = 0;
    end else begin
      push = out_req && (m_fifo.size() < DEPTH);
      pop  = (m_left == 0) && (m_fifo.size() > 0);
      if (pop) begin
        m_cur  = m_fifo.pop_front();
        m_left = FRAME;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (push) begin
        m_fifo.push_back(out_data[7:0]);
        sb_q.push_back(out_data[7:0]);
      end
    end
  end

  function automatic logic exp_txd();
    int b;
    if (m_left == 0) return 1'b1;
    b = (FRAME - m_left) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      check("txd", txd, exp_txd());
      check("out_busy", out_busy, m_fifo.size() == DEPTH);
      check("fifo_count", fifo_count, m_fifo.size());
      check("tx_active", tx_active, m_left > 0);
    end
  end

  // UART decoder: mid-bit sampling relative to the first low sample.
  bit         mf;
  int         mt;
  logic [7:0] mb;

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      mf = 1'b0;
    end else if (!mf) begin
      if (txd === 1'b0) begin
        mf = 1'b1;
        mt = 0;
      end
    end else begin
      mt++;
      if (mt == CPB/2) check("start_bit", txd, 1'b0);
      for (int i = 0; i < 8; i++)
        if (mt == (i+1)*CPB + CPB/2) mb[i] = txd;
      if (mt == 9*CPB + CPB/2) begin
        check("stop_bit", txd, 1'b1);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_unexpected: actual byte 0x%0h required none", mb);
        end else begin
          check("frame_byte", mb, sb_q.pop_front());
        end
      end
      if (mt == FRAME-1) mf = 1'b0;
    end
  end

  int last_acc;

  // Core-side driver: hold the request until a cycle where the unit is not busy.
  task automatic send(input logic [31:0] v);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    out_req  = 1'b1;
    out_data = v;
    while (!acc && n < 2000) begin
      acc = !out_busy;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    last_acc = cyc;
    check("send_accept", acc, 1'b1);
    out_req  = 1'b0;
    out_data = $urandom;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      done = (m_fifo.size() == 0) && (m_left == 0) && (sb_q.size() == 0) && !mf;
    end
    check("drain", done, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc1, gap;
    bit hit;
    rstn     = 1'b0;
    out_req  = 1'b0;
    out_data = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", out_busy, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_active", tx_active, 1'b0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    send(32'hFFFF_FF41);
    wait_drain();

    send(32'h0000_0055);
    send(32'h1234_56A3);
    wait_drain();

    for (int k = 1; k <= 6; k++) begin
      send(32'(k));
      if (k == 1) acc1 = last_acc;
      if (k == 5) begin
        check("bp_full_count", fifo_count, DEPTH);
        check("bp_full_busy", out_busy, 1'b1);
      end
    end
    check("bp_byte6_cycle", last_acc - acc1, 43);
    wait_drain();

    send(32'h11);
    send(32'h22);
    send(32'h33);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_left == 0 && m_fifo.size() == 2) hit = 1'b1;
      else @(negedge clk);
    end
    check("pp_setup", hit, 1'b1);
    send(32'h44);
    check("pp_count", fifo_count, 2);
    wait_drain();

    for (int k = 0; k < 20; k++) send($urandom);
    wait_drain();

    send(32'h00);
    send(32'hC5);
    send(32'h3C);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (m_left > 0 && (FRAME - m_left) / CPB == 4) hit = 1'b1;
    end
    check("mid_reset_setup", hit, 1'b1);
    check("mid_reset_pre_txd", txd, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("mid_reset_txd", txd, 1'b1);
    check("mid_reset_count", fifo_count, 0);
    check("mid_reset_active", tx_active, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    wait_drain();

    for (int k = 0; k < 500; k++) begin
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 80) : $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      send($urandom);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
